// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and helpers for the NCO I/Q monitor
package nco_pkg;

  localparam int DEF_DATA_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  typedef logic [1:0] quad_t;

  // Quadrant from the sign bits of sin/cos; zero counts as non-negative.
  // Numbering follows counter-clockwise rotation so a legal step is +1 mod 4.
  function automatic quad_t quadrant_of(input logic sin_neg, input logic cos_neg);
    case ({cos_neg, sin_neg})
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/nco_quad_classify.sv
// rtl/nco_quad_classify.sv - combinational quadrant, step-legality and zero-crossing flags
module nco_quad_classify
  import nco_pkg::*;
(
  input  logic       sin_neg,
  input  logic       cos_neg,
  input  logic       prev_sin_neg,
  input  logic [1:0] prev_quad,
  output logic [1:0] quad,
  output logic       illegal,
  output logic       zc_rise
);

  logic [1:0] step;

  // Step of 0 or +1 is legal; -1 (3) and +2 both have the MSB of the mod-4 step set
  always_comb begin
    quad    = quadrant_of(sin_neg, cos_neg);
    step    = quad - prev_quad;
    illegal = step[1];
    zc_rise = prev_sin_neg && !sin_neg;
  end

endmodule

// File: rtl/nco_iq_monitor.sv
// rtl/nco_iq_monitor.sv - gated frequency/amplitude/quadrature monitor for the NCO output stream
module nco_iq_monitor
  import nco_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GATE_W = 20,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] fsin_i,
  input  logic [DATA_W-1:0] fcos_i,
  output logic              busy,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  zc_count,
  output logic [DATA_W-1:0] sin_max,
  output logic [DATA_W-1:0] sin_min,
  output logic [CNT_W-1:0]  quad_err
);

  localparam logic [DATA_W-1:0] NEG_THRESH = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t            state;
  logic [GATE_W-1:0] remaining;
  logic [GATE_W-1:0] gate_eff;
  logic              prev_sin_neg;
  logic [1:0]        prev_quad;

  logic              sin_neg;
  logic              cos_neg;
  logic [1:0]        quad;
  logic              illegal;
  logic              zc_rise;
  logic              arm;

  // Sample signs, effective gate length and the start-acceptance condition
  always_comb begin
    sin_neg  = (fsin_i >= NEG_THRESH);
    cos_neg  = (fcos_i >= NEG_THRESH);
    gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;
    arm      = start && ((state == IDLE) || ((state == REPORT) && meas_ready));
  end

  nco_quad_classify u_classify (
    .sin_neg      (sin_neg),
    .cos_neg      (cos_neg),
    .prev_sin_neg (prev_sin_neg),
    .prev_quad    (prev_quad),
    .quad         (quad),
    .illegal      (illegal),
    .zc_rise      (zc_rise)
  );

  // Measurement FSM with its counters, min/max trackers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      prev_sin_neg <= 1'b0;
      prev_quad    <= '0;
      busy         <= 1'b0;
      meas_valid   <= 1'b0;
      zc_count     <= '0;
      sin_max      <= '0;
      sin_min      <= '0;
      quad_err     <= '0;
    end else if (arm) begin
      // Accepted start (from IDLE, or back-to-back from REPORT): fresh window
      state        <= PRIME;
      remaining    <= gate_eff;
      prev_sin_neg <= 1'b0;
      prev_quad    <= '0;
      busy         <= 1'b1;
      meas_valid   <= 1'b0;
      zc_count     <= '0;
      sin_max      <= '0;
      sin_min      <= '0;
      quad_err     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          busy       <= 1'b0;
          meas_valid <= 1'b0;
        end
        PRIME: begin
          // Seed sample: establishes history only, not counted against the gate
          if (in_valid) begin
            prev_sin_neg <= sin_neg;
            prev_quad    <= quad;
            sin_max      <= fsin_i;
            sin_min      <= fsin_i;
            state        <= MEASURE;
          end
        end
        MEASURE: begin
          if (in_valid) begin
            if (zc_rise && (zc_count != CNT_MAX)) begin
              zc_count <= zc_count + 1'b1;
            end
            if (illegal && (quad_err != CNT_MAX)) begin
              quad_err <= quad_err + 1'b1;
            end
            if ($signed(fsin_i) > $signed(sin_max)) begin
              sin_max <= fsin_i;
            end
            if ($signed(fsin_i) < $signed(sin_min)) begin
              sin_min <= fsin_i;
            end
            prev_sin_neg <= sin_neg;
            prev_quad    <= quad;
            remaining    <= remaining - 1'b1;
            if (remaining == GATE_W'(1)) begin
              state      <= REPORT;
              busy       <= 1'b0;
              meas_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (meas_ready) begin
            meas_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_iq_monitor.sv
// tb/tb_nco_iq_monitor.sv - scoreboard bench for nco_iq_monitor
module tb_nco_iq_monitor;

  localparam int DATA_W = 14;
  localparam int GATE_W = 20;
  localparam int CNT_W  = 20;
  localparam real PI    = 3.14159265358979323846;

  logic              clk;
  logic              reset;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              in_valid;
  logic [DATA_W-1:0] fsin_i;
  logic [DATA_W-1:0] fcos_i;
  logic              busy;
  logic              meas_valid;
  logic              meas_ready;
  logic [CNT_W-1:0]  zc_count;
  logic [DATA_W-1:0] sin_max;
  logic [DATA_W-1:0] sin_min;
  logic [CNT_W-1:0]  quad_err;

  nco_iq_monitor #(.DATA_W(DATA_W), .GATE_W(GATE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gate_len   (gate_len),
    .in_valid   (in_valid),
    .fsin_i     (fsin_i),
    .fcos_i     (fcos_i),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .zc_count   (zc_count),
    .sin_max    (sin_max),
    .sin_min    (sin_min),
    .quad_err   (quad_err)
  );

  typedef struct {
    int zc;
    int mx;
    int mn;
    int qe;
  } exp_t;

  exp_t exp_q[$];
  int   sin_q[$];
  int   cos_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Reference quadrant straight from the angle-sector definition
  function automatic int quad_ref(input int s, input int c);
    if (c >= 0 && s >= 0) return 0;
    if (c < 0 && s >= 0)  return 1;
    if (c < 0 && s < 0)   return 2;
    return 3;
  endfunction

  // Build seed + n gated samples of the requested kind
  task automatic gen_window(input int kind, input int n);
    real ph, stp, amp;
    sin_q.delete();
    cos_q.delete();
    ph  = $urandom_range(0, 6283) / 1000.0;
    stp = ($urandom_range(10, 900) / 1000.0) * (($urandom_range(0, 1) == 1) ? 1.0 : -1.0);
    amp = real'($urandom_range(100, 8191));
    for (int i = 0; i <= n; i++) begin
      case (kind)
        0: begin sin_q.push_back(rnd(8191.0 * $sin(2.0*PI*i/100.0)));  cos_q.push_back(rnd(8191.0 * $cos(2.0*PI*i/100.0))); end
        1: begin sin_q.push_back(-rnd(8191.0 * $sin(2.0*PI*i/100.0))); cos_q.push_back(rnd(8191.0 * $cos(2.0*PI*i/100.0))); end
        2: begin sin_q.push_back(-1); cos_q.push_back(0); end
        3: begin sin_q.push_back(rnd(amp * $sin(ph + stp*i))); cos_q.push_back(rnd(amp * $cos(ph + stp*i))); end
        default: begin
          sin_q.push_back(int'($urandom_range(0, 16383)) - 8192);
          cos_q.push_back(int'($urandom_range(0, 16383)) - 8192);
        end
      endcase
    end
  endtask

  // Reference result: window statistics over the generated samples
  task automatic push_expected();
    exp_t e;
    int pq, q;
    e.mx = sin_q[0];
    e.mn = sin_q[0];
    e.zc = 0;
    e.qe = 0;
    pq = quad_ref(sin_q[0], cos_q[0]);
    for (int i = 1; i < sin_q.size(); i++) begin
      q = quad_ref(sin_q[i], cos_q[i]);
      if (sin_q[i-1] < 0 && sin_q[i] >= 0) e.zc = (e.zc < (1 << CNT_W) - 1) ? e.zc + 1 : e.zc;
      if (((q - pq + 4) % 4) >= 2)         e.qe = (e.qe < (1 << CNT_W) - 1) ? e.qe + 1 : e.qe;
      if (sin_q[i] > e.mx) e.mx = sin_q[i];
      if (sin_q[i] < e.mn) e.mn = sin_q[i];
      pq = q;
    end
    exp_q.push_back(e);
  endtask

  task automatic arm(input int glen);
    start    = 1'b1;
    gate_len = GATE_W'(glen);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Drive the first `count` samples; optional every-third-cycle gap and a stray start mid-window
  task automatic feed(input int count, input bit gap, input bit mid_start);
    int idx = 0;
    int cyc = 0;
    bit busy_ok = 1'b1;
    while (idx < count) begin
      start    = mid_start && (idx == 5);
      gate_len = start ? GATE_W'(3) : gate_len;
      if (gap && (cyc % 3 == 2)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        fsin_i   = DATA_W'(sin_q[idx]);
        fcos_i   = DATA_W'(cos_q[idx]);
        idx++;
      end
      if (!busy) busy_ok = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (gap) check("busy_during_gapped_window", int'(busy_ok), 1);
  endtask

  // Result must appear exactly one edge after the last sample, then handshake it away
  task automatic finish_window(input string tag);
    int wait_cnt = 0;
    check({tag, "_latency"}, int'(meas_valid), 1);
    while (!meas_valid && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    meas_ready = 1'b1;
    @(posedge clk); #1;
    meas_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(meas_valid), 0);
  endtask

  task automatic run_window(input string tag, input int kind, input int glen, input bit gap, input bit mid_start);
    gen_window(kind, (glen == 0) ? 1 : glen);
    push_expected();
    arm(glen);
    feed(sin_q.size(), gap, mid_start);
    finish_window(tag);
  endtask

  // Scoreboard monitor: pops and compares on every result handshake
  always @(negedge clk) begin
    if (!reset && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("zc_count", int'(zc_count), e.zc);
        check("sin_max",  int'($signed(sin_max)), e.mx);
        check("sin_min",  int'($signed(sin_min)), e.mn);
        check("quad_err", int'(quad_err), e.qe);
      end
    end
  end

  initial begin
    bit hold_ok;
    reset      = 1'b1;
    start      = 1'b0;
    gate_len   = '0;
    in_valid   = 1'b0;
    fsin_i     = '0;
    fcos_i     = '0;
    meas_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       int'(busy), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_zc_count",   int'(zc_count), 0);
    check("rst_quad_err",   int'(quad_err), 0);
    reset = 1'b0;

    // Ideal forward rotation, reverse rotation, gapped ideal stream
    run_window("ideal",   0, 1000, 1'b0, 1'b0);
    run_window("reverse", 1, 1000, 1'b0, 1'b0);
    run_window("gapped",  0, 1000, 1'b1, 1'b0);

    // Held result, then back-to-back consume + start with gate_len=1
    gen_window(0, 200);
    push_expected();
    arm(200);
    feed(sin_q.size(), 1'b0, 1'b0);
    check("hold_latency", int'(meas_valid), 1);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!meas_valid || int'(zc_count) != exp_q[0].zc || int'($signed(sin_max)) != exp_q[0].mx ||
          int'($signed(sin_min)) != exp_q[0].mn || int'(quad_err) != exp_q[0].qe) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("hold_stable", int'(hold_ok), 1);
    gen_window(4, 1);
    push_expected();
    meas_ready = 1'b1;
    start      = 1'b1;
    gate_len   = GATE_W'(1);
    @(posedge clk); #1;
    meas_ready = 1'b0;
    start      = 1'b0;
    check("rearm_busy", int'(busy), 1);
    check("rearm_valid", int'(meas_valid), 0);
    feed(sin_q.size(), 1'b0, 1'b0);
    finish_window("rearm");

    // Reset in the middle of a window aborts it cleanly
    gen_window(0, 1000);
    arm(1000);
    feed(501, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy",       int'(busy), 0);
    check("abort_meas_valid", int'(meas_valid), 0);
    check("abort_zc_count",   int'(zc_count), 0);
    check("abort_sin_max",    int'(sin_max), 0);
    check("abort_sin_min",    int'(sin_min), 0);
    check("abort_quad_err",   int'(quad_err), 0);
    run_window("after_abort", 0, 1000, 1'b0, 1'b0);

    // Edge inputs: gate 0, stray start during MEASURE, constant negative sine
    run_window("gate_zero", 4, 0, 1'b0, 1'b0);
    run_window("mid_start", 3, 20, 1'b0, 1'b1);
    run_window("const_neg", 2, 30, 1'b0, 1'b0);

    // Randomized windows
    for (int k = 0; k < 10; k++) begin
      run_window("random", 3 + int'($urandom_range(0, 1)), int'($urandom_range(0, 60)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
